// File: rtl/vga_scan_driver_pkg.sv
// Shared timing constants, sync/blank bundle type and window helper for the VGA scan-out stage.
// The 640x480@60 raster defaults live here in place of the old constants.vh.
package vga_scan_driver_pkg;

  localparam int unsigned X_DISPLAY = 640;
  localparam int unsigned Y_DISPLAY = 480;
  localparam int unsigned H_FP      = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BP      = 48;
  localparam int unsigned V_FP      = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BP      = 33;

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned CNT_MAX = 1 << CNT_W;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0};

  function automatic logic in_window(input int unsigned v, input int unsigned lo,
                                     input int unsigned len);
    return (v >= lo) && (v < lo + len);
  endfunction

endpackage

// File: rtl/vga_scan_driver_scan_counter.sv
// Tick-enabled wrap counter for one raster axis: raw active-low sync, next-count
// visibility and a wrap strobe that can enable the next axis.
module scan_counter
  import vga_scan_driver_pkg::*;
#(
  parameter int unsigned TOTAL      = 800,
  parameter int unsigned SYNC_START = 656,
  parameter int unsigned SYNC_LEN   = 96,
  parameter int unsigned VIS        = 640
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             sync_n,
  output logic             vis_nxt,
  output logic             wrap
);

  logic             at_end;
  logic [CNT_W-1:0] cnt_nxt;

  // vis_nxt looks at the value being loaded so the owner can register visibility
  // in the same edge as the counts.
  always_comb begin
    at_end  = (32'(cnt) == TOTAL - 1);
    wrap    = en && at_end;
    cnt_nxt = cnt;
    if (en) begin
      cnt_nxt = at_end ? '0 : cnt + CNT_W'(1);
    end
    vis_nxt = (32'(cnt_nxt) < VIS);
    sync_n  = !in_window(32'(cnt), SYNC_START, SYNC_LEN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/vga_scan_driver.sv
// VGA scan-out: raster x/y generation for the pixel generator, sync/blank delay
// matched to the generator latency, and registered DAC pin drive.
module vga_scan_driver
  import vga_scan_driver_pkg::*;
#(
  parameter int unsigned H_VIS   = X_DISPLAY,
  parameter int unsigned H_FP    = vga_scan_driver_pkg::H_FP,
  parameter int unsigned H_SYNC  = vga_scan_driver_pkg::H_SYNC,
  parameter int unsigned H_BP    = vga_scan_driver_pkg::H_BP,
  parameter int unsigned V_VIS   = Y_DISPLAY,
  parameter int unsigned V_FP    = vga_scan_driver_pkg::V_FP,
  parameter int unsigned V_SYNC  = vga_scan_driver_pkg::V_SYNC,
  parameter int unsigned V_BP    = vga_scan_driver_pkg::V_BP,
  parameter int unsigned PIPE    = 1,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [11:0]      pixel_in,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             pix_tick,
  output logic             visible,
  output logic             frame_start,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic [3:0]       vga_r,
  output logic [3:0]       vga_g,
  output logic [3:0]       vga_b
);

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_bad_total
    $error("vga_scan_driver: H_TOTAL/V_TOTAL exceed 10-bit counters");
  end
  if (PIPE > 4) begin : g_bad_pipe
    $error("vga_scan_driver: PIPE must be 0..4");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_scan_driver: CLK_DIV must be >= 1");
  end

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_nxt;
  logic             tick_q;

  // The tick is registered from the next divider value so it is low in reset
  // even when CLK_DIV=1.
  always_comb begin
    div_nxt = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_nxt;
      tick_q <= (div_nxt == DIV_LAST);
    end
  end

  assign pix_tick = tick_q;

  logic hs_raw, vs_raw;
  logic h_vis_nxt, v_vis_nxt;
  logic h_wrap, v_wrap;

  scan_counter #(
    .TOTAL      (H_TOTAL),
    .SYNC_START (H_VIS + H_FP),
    .SYNC_LEN   (H_SYNC),
    .VIS        (H_VIS)
  ) u_h (
    .clk     (clk),
    .reset   (reset),
    .en      (tick_q),
    .cnt     (x),
    .sync_n  (hs_raw),
    .vis_nxt (h_vis_nxt),
    .wrap    (h_wrap)
  );

  scan_counter #(
    .TOTAL      (V_TOTAL),
    .SYNC_START (V_VIS + V_FP),
    .SYNC_LEN   (V_SYNC),
    .VIS        (V_VIS)
  ) u_v (
    .clk     (clk),
    .reset   (reset),
    .en      (h_wrap),
    .cnt     (y),
    .sync_n  (vs_raw),
    .vis_nxt (v_vis_nxt),
    .wrap    (v_wrap)
  );

  // v_wrap already implies the tick and the H wrap, so it marks the edge loading 0,0.
  assign frame_start = v_wrap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      visible <= 1'b0;
    end else if (tick_q) begin
      visible <= h_vis_nxt && v_vis_nxt;
    end
  end

  sync_t raw;
  sync_t dly;

  assign raw = '{hs: hs_raw, vs: vs_raw, de: visible};

  if (PIPE == 0) begin : g_no_dly
    assign dly = raw;
  end else begin : g_dly
    sync_t stage [PIPE];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int unsigned i = 0; i < PIPE; i++) begin
          stage[i] <= SYNC_IDLE;
        end
      end else if (tick_q) begin
        stage[0] <= raw;
        for (int unsigned i = 1; i < PIPE; i++) begin
          stage[i] <= stage[i-1];
        end
      end
    end

    assign dly = stage[PIPE-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
    end else if (tick_q) begin
      vga_hs <= dly.hs;
      vga_vs <= dly.vs;
      if (dly.de) begin
        {vga_r, vga_g, vga_b} <= pixel_in;
      end else begin
        {vga_r, vga_g, vga_b} <= '0;
      end
    end
  end

endmodule
